// File: rtl/imul_share_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier among p_nreqs requesters, one transaction in flight.
// Optional macro IMUL_SHARE_ARBITER_ZERO_BYPASS_EN answers zero-operand requests locally with a zero product.
module imul_share_arbiter #(
  parameter int p_nreqs = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_nreqs-1:0]     req_val,
  output logic [p_nreqs-1:0]     req_rdy,
  input  logic [64*p_nreqs-1:0]  req_msg,
  output logic [p_nreqs-1:0]     resp_val,
  input  logic [p_nreqs-1:0]     resp_rdy,
  output logic [32*p_nreqs-1:0]  resp_msg,
  output logic                   mul_req_val,
  input  logic                   mul_req_rdy,
  output logic [63:0]            mul_req_msg,
  input  logic                   mul_resp_val,
  output logic                   mul_resp_rdy,
  input  logic [31:0]            mul_resp_msg
);

  localparam int c_idx_nbits = $clog2(p_nreqs);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT   = 2'd2
`ifdef IMUL_SHARE_ARBITER_ZERO_BYPASS_EN
    , BYPASS = 2'd3
`endif
  } state_t;

  state_t                 state, state_next;
  logic [c_idx_nbits-1:0] rr_ptr, owner, grant, ptr_next;
  logic [63:0]            op_reg, grant_msg;
  logic                   any_val, take, done;
  int                     idx;

  // Scan starting at rr_ptr so the requester after the last winner has top priority.
  always_comb begin
    grant   = rr_ptr;
    any_val = 1'b0;
    idx     = 0;
    for (int k = 0; k < p_nreqs; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= p_nreqs) idx = idx - p_nreqs;
      if (!any_val && req_val[idx]) begin
        grant   = c_idx_nbits'(idx);
        any_val = 1'b1;
      end
    end
  end

  assign grant_msg = req_msg[64*grant +: 64];
  assign ptr_next  = (owner == c_idx_nbits'(p_nreqs-1)) ? '0 : owner + c_idx_nbits'(1);

  always_comb begin
    state_next   = state;
    take         = 1'b0;
    done         = 1'b0;
    req_rdy      = '0;
    resp_val     = '0;
    resp_msg     = '0;
    mul_req_val  = 1'b0;
    mul_req_msg  = '0;
    mul_resp_rdy = 1'b0;
    case (state)
      IDLE: begin
        if (any_val) begin
          req_rdy[grant] = 1'b1;
          take           = 1'b1;
          state_next     = SEND;
`ifdef IMUL_SHARE_ARBITER_ZERO_BYPASS_EN
          if (grant_msg[63:32] == 32'd0 || grant_msg[31:0] == 32'd0) state_next = BYPASS;
`endif
        end
      end
      SEND: begin
        mul_req_val = 1'b1;
        mul_req_msg = op_reg;
        if (mul_req_rdy) state_next = WAIT;
      end
      WAIT: begin
        resp_val[owner]          = mul_resp_val;
        resp_msg[32*owner +: 32] = mul_resp_msg;
        mul_resp_rdy             = resp_rdy[owner];
        if (mul_resp_val && resp_rdy[owner]) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
`ifdef IMUL_SHARE_ARBITER_ZERO_BYPASS_EN
      BYPASS: begin
        resp_val[owner] = 1'b1;
        if (resp_rdy[owner]) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
    // Hold every handshake output low while reset is asserted, even though IDLE is combinational on req_val.
    if (reset) begin
      req_rdy      = '0;
      resp_val     = '0;
      resp_msg     = '0;
      mul_req_val  = 1'b0;
      mul_req_msg  = '0;
      mul_resp_rdy = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      op_reg <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        op_reg <= grant_msg;
        owner  <= grant;
      end
      if (done) rr_ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_imul_share_arbiter.sv
// Bench for imul_share_arbiter with a fixed-latency multiplier model; define
// IMUL_SHARE_ARBITER_ZERO_BYPASS_EN here too when building the bypass variant.
module tb_imul_share_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_val, req_rdy, resp_val, resp_rdy;
  logic [255:0] req_msg;
  logic [127:0] resp_msg;
  logic         mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;
  logic [63:0]  mul_req_msg;
  logic [31:0]  mul_resp_msg;

  int n_checks = 0;
  int n_fail   = 0;

  imul_share_arbiter #(.p_nreqs(4)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
    .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg)
  );

  always #5 clk = ~clk;

  // Multiplier model: accepts when idle, answers after m_lat cycles, shares the arbiter reset.
  logic        m_busy, mul_accept_en;
  logic [3:0]  m_cnt;
  logic [31:0] m_prod;
  localparam logic [3:0] m_lat = 4'd5;

  assign mul_req_rdy  = !m_busy && mul_accept_en;
  assign mul_resp_val = m_busy && (m_cnt == 4'd0);
  assign mul_resp_msg = m_prod;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 4'd0;
      m_prod <= 32'd0;
    end else if (!m_busy) begin
      if (mul_req_val && mul_req_rdy) begin
        m_busy <= 1'b1;
        m_cnt  <= m_lat;
        m_prod <= mul_req_msg[63:32] * mul_req_msg[31:0];
      end
    end else if (m_cnt != 4'd0) begin
      m_cnt <= m_cnt - 4'd1;
    end else if (mul_resp_rdy) begin
      m_busy <= 1'b0;
    end
  end

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
  } vec_t;

  vec_t vecs [4];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_val                 = 4'b0000;
    req_val[idx]            = 1'b1;
    req_msg[64*idx +: 64]   = {a, b};
  endtask

  task automatic wait_resp(input string name, input int idx, input logic [31:0] prod);
    int n = 0;
    logic [127:0] m;
    while (resp_val == 4'b0000 && n < 100) begin
      cycle();
      n++;
    end
    m = {96'd0, 32'hFFFF_FFFF} << (32*idx);
    checkOutput({name, "_resp_val"}, 128'(resp_val), 128'(4'b0001 << idx));
    checkOutput({name, "_prod"}, 128'(resp_msg[32*idx +: 32]), 128'(prod));
    checkOutput({name, "_other_slices"}, resp_msg & ~m, 128'd0);
    cycle();
  endtask

  task automatic do_txn(input string name, input int idx, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] prod);
    resp_rdy = 4'b1111;
    applyStimulus(idx, a, b);
    #1;
    checkOutput({name, "_grant"}, 128'(req_rdy), 128'(4'b0001 << idx));
    checkOutput({name, "_no_issue_yet"}, 128'(mul_req_val), 128'd0);
    cycle();
    req_val = 4'b0000;
    checkOutput({name, "_issue"}, 128'(mul_req_val), 128'd1);
    checkOutput({name, "_operands"}, 128'(mul_req_msg), 128'({a, b}));
    wait_resp(name, idx, prod);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int order [5];
    int g, r, n;

    vecs[0] = '{0, 32'd3,          32'd4,          32'd12};
    vecs[1] = '{1, 32'd5,          32'd7,          32'd35};
    vecs[2] = '{2, 32'h0001_0000,  32'h0001_0000,  32'd0};
    vecs[3] = '{3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1};
    order   = '{0, 1, 2, 3, 0};

    // Reset with every requester asking: nothing may be granted or issued.
    reset = 1'b1;
    req_val = 4'b1111;
    resp_rdy = 4'b1111;
    req_msg = '0;
    mul_accept_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_rdy", 128'(req_rdy), 128'd0);
    checkOutput("rst_mul_req_val", 128'(mul_req_val), 128'd0);
    checkOutput("rst_mul_resp_rdy", 128'(mul_resp_rdy), 128'd0);
    checkOutput("rst_resp_val", 128'(resp_val), 128'd0);
    checkOutput("rst_resp_msg", resp_msg, 128'd0);
    checkOutput("rst_mul_req_msg", 128'(mul_req_msg), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    req_val = 4'b0000;
    cycle();

    for (int i = 0; i < 4; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].prod);
    end

    // All four requesters hold val: grants rotate 0,1,2,3 then wrap to 0.
    for (int i = 0; i < 4; i++) req_msg[64*i +: 64] = {32'(2*i+1), 32'd1};
    req_val = 4'b1111;
    resp_rdy = 4'b1111;
    #1;
    g = 0; r = 0; n = 0;
    while (r < 5 && n < 300) begin
      if (req_rdy != 4'b0000 && g < 5) begin
        checkOutput($sformatf("rr_grant%0d", g), 128'(req_rdy), 128'(4'b0001 << order[g]));
        g++;
      end
      if (resp_val != 4'b0000) begin
        checkOutput($sformatf("rr_resp_val%0d", r), 128'(resp_val), 128'(4'b0001 << order[r]));
        checkOutput($sformatf("rr_prod%0d", r), 128'(resp_msg[32*order[r] +: 32]), 128'(2*order[r]+1));
        r++;
      end
      if (r < 5) begin
        cycle();
        n++;
      end
    end
    checkOutput("rr_resp_count", 128'(r), 128'd5);
    req_val = 4'b0000;
    cycle();

    // Requester 2 stalls its response; requester 0 waits behind it.
    applyStimulus(2, 32'hFFFF_FFFF, 32'd2);
    req_msg[63:0] = {32'd3, 32'd4};
    resp_rdy = 4'b1011;
    #1;
    checkOutput("bp_grant2", 128'(req_rdy), 128'(4'b0100));
    cycle();
    req_val = 4'b0101;
    n = 0;
    while (resp_val == 4'b0000 && n < 100) begin
      cycle();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("bp_mul_resp_rdy%0d", i), 128'(mul_resp_rdy), 128'd0);
      checkOutput($sformatf("bp_resp_val%0d", i), 128'(resp_val), 128'(4'b0100));
      checkOutput($sformatf("bp_no_grant%0d", i), 128'(req_rdy), 128'd0);
      cycle();
    end
    resp_rdy = 4'b1111;
    #1;
    checkOutput("bp_release_rdy", 128'(mul_resp_rdy), 128'd1);
    checkOutput("bp_prod", 128'(resp_msg[95:64]), 128'(32'hFFFF_FFFE));
    cycle();
    checkOutput("bp_next_grant0", 128'(req_rdy), 128'(4'b0001));
    cycle();
    req_val = 4'b0000;
    checkOutput("bp_issue0", 128'(mul_req_msg), 128'({32'd3, 32'd4}));
    wait_resp("bp_req0", 0, 32'd12);

    // Multiplier refuses the request for four cycles; operands must hold.
    mul_accept_en = 1'b0;
    applyStimulus(1, 32'd11, 32'd13);
    #1;
    checkOutput("stall_grant1", 128'(req_rdy), 128'(4'b0010));
    cycle();
    req_val = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("stall_val%0d", i), 128'(mul_req_val), 128'd1);
      checkOutput($sformatf("stall_msg%0d", i), 128'(mul_req_msg), 128'({32'd11, 32'd13}));
      cycle();
    end
    mul_accept_en = 1'b1;
    wait_resp("stall", 1, 32'd143);

    // Asynchronous reset while waiting on the multiplier abandons the transaction.
    applyStimulus(0, 32'd5, 32'd5);
    #1;
    cycle();
    req_val = 4'b0000;
    cycle();
    cycle();
    applyStimulus(3, 32'd7, 32'd6);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_mul_resp_rdy", 128'(mul_resp_rdy), 128'd0);
    checkOutput("mid_rst_req_rdy", 128'(req_rdy), 128'd0);
    checkOutput("mid_rst_resp_val", 128'(resp_val), 128'd0);
    checkOutput("mid_rst_mul_req_val", 128'(mul_req_val), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_grant3", 128'(req_rdy), 128'(4'b1000));
    cycle();
    req_val = 4'b0000;
    checkOutput("post_rst_operands", 128'(mul_req_msg), 128'({32'd7, 32'd6}));
    wait_resp("post_rst", 3, 32'd42);

    // Zero operand: bypassed locally when the feature is built in, else multiplied.
`ifdef IMUL_SHARE_ARBITER_ZERO_BYPASS_EN
    resp_rdy = 4'b1111;
    applyStimulus(1, 32'd0, 32'd9);
    #1;
    checkOutput("zero_grant1", 128'(req_rdy), 128'(4'b0010));
    cycle();
    req_val = 4'b0000;
    checkOutput("zero_resp_val", 128'(resp_val), 128'(4'b0010));
    checkOutput("zero_resp_msg", resp_msg, 128'd0);
    checkOutput("zero_no_mul", 128'(mul_req_val), 128'd0);
    cycle();
    checkOutput("zero_done", 128'(resp_val), 128'd0);
    checkOutput("zero_still_no_mul", 128'(mul_req_val), 128'd0);
`else
    do_txn("zero", 1, 32'd0, 32'd9, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imul_share_arbiter.md
Name: imul_share_arbiter

Overview:
- Round-robin arbiter that shares one iterative integer multiplier (64-bit request {a,b}, 32-bit product, val/rdy streams) among p_nreqs requesters.
- Sits between several client streams and a single multiplier instance.
- Accepts one request, issues it to the multiplier, and routes the product back to the owning requester.
- Allows exactly one transaction in flight.

Parameters:
p_nreqs, 4, number of requesters (legal 2..8); index width c_idx_nbits = $clog2(p_nreqs)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
req_val  input  p_nreqs  per-requester request valid
req_rdy  output  p_nreqs  per-requester request ready
req_msg  input  64*p_nreqs  requester i occupies bits [64i+63:64i]; {a[63:32], b[31:0]}
resp_val  output  p_nreqs  per-requester response valid
resp_rdy  input  p_nreqs  per-requester response ready
resp_msg  output  32*p_nreqs  requester i occupies bits [32i+31:32i]; product
mul_req_val  output  1  request valid to multiplier
mul_req_rdy  input  1  multiplier request ready
mul_req_msg  output  64  operands to multiplier
mul_resp_val  input  1  multiplier response valid
mul_resp_rdy  output  1  response ready to multiplier
mul_resp_msg  input  32  product from multiplier

Behaviour:
- Interface: one clock, clk. reset is asynchronous, active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, owner=0, op_reg=0.
  - While reset is high: all req_rdy, resp_val, mul_req_val, mul_resp_rdy = 0; mul_req_msg=0; resp_msg=0.
- State register: state, owner, op_reg and rr_ptr update on posedge clk or posedge reset.
- IDLE:
  - grant = first i with req_val[i]=1, scanning rr_ptr, rr_ptr+1, … modulo p_nreqs.
  - req_rdy = one-hot(grant) if any req_val, else 0. req_rdy may depend combinationally on req_val.
  - On handshake: op_reg <= req_msg[grant], owner <= grant, go to SEND.
  - All other outputs 0.
- SEND:
  - mul_req_val=1, mul_req_msg=op_reg. op_reg is held stable until accepted.
  - On mul_req_rdy=1, go to WAIT.
  - req_rdy=0.
- WAIT (combinational pass-through):
  - resp_val[owner]=mul_resp_val; mul_resp_rdy=resp_rdy[owner].
  - resp_msg for the owner slice = mul_resp_msg. All other resp_val=0; other slices of resp_msg=0.
  - On mul_resp_val & resp_rdy[owner]: rr_ptr <= (owner+1) mod p_nreqs (wrap from p_nreqs-1 to 0), go to IDLE.
- Latency:
  - Request accepted in cycle n; issued to the multiplier in n+1 at the earliest.
  - Response appears the same cycle the multiplier asserts mul_resp_val.
  - Next grant is no earlier than the cycle after the response handshake.
- Backpressure:
  - Requesters waiting in IDLE hold req_val.
  - Non-granted requesters see req_rdy=0 and are not dropped.
  - Responder backpressure (resp_rdy=0) stalls the multiplier via mul_resp_rdy.
- Simultaneous events:
  - Multiple req_val: the round-robin winner only.
  - A requester re-requesting in the same cycle its response completes is granted no earlier than the next IDLE cycle, at lowest priority.
- Reset mid-transaction:
  - Any in-flight transaction is abandoned and no response is produced.
  - The multiplier must share the same reset.
- Illegal state encodings return to IDLE.

Optional Feature:
Macro: IMUL_SHARE_ARBITER_ZERO_BYPASS_EN.
- Defined:
  - IDLE checks the granted operands. If a==0 or b==0, capture owner and go to state BYPASS instead of SEND; the multiplier is not touched.
  - BYPASS: resp_val[owner]=1 with resp_msg slice=0, mul_req_val=0.
  - On resp_rdy[owner]: update rr_ptr as in WAIT and go to IDLE.
- Undefined: the BYPASS state and zero-detect logic are absent; zero operands go through SEND/WAIT like any other request.

Test Plan:
1. Single requester 0 sends a=3, b=4; multiplier model fixed latency 5 → resp_val[0] with 12; mul_req_val asserted exactly one cycle after acceptance; no other resp_val.
2. Requesters 0–3 all hold val continuously, products 2*i+1 → grants in order 0,1,2,3,0; each response routed to the correct slice; rr_ptr wraps 3→0.
3. Requester 2 sends a=0xFFFFFFFF, b=2 with resp_rdy[2]=0 for 10 cycles → mul_resp_rdy=0 throughout; 0xFFFFFFFE delivered when resp_rdy[2] rises; next grant only afterwards.
4. Requester 1 request accepted, mul_req_rdy held 0 for 4 cycles → mul_req_msg is stable and mul_req_val=1 for all 4 cycles; transaction completes correctly once accepted.
5. Reset asserted asynchronously in WAIT → outputs go 0 immediately; after release, a new request a=7, b=6 from requester 3 returns 42, and no stale response appears.
6. With ZERO_BYPASS_EN, requester 1 sends a=0, b=9 → resp_msg slice 1 = 0 one cycle after acceptance with mul_req_val never asserted; without the macro, the same stimulus goes through the multiplier and returns 0.
